// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller slice.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_t;

  localparam int FLOOR_W = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_if.sv
// Call-button inputs and car status outputs of the elevator controller.
interface elevator_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 10
);

  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    floor;
  logic                  disp_en;
  logic                  door_open;
  logic                  moving_up;
  logic                  moving_down;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output req,
    input  floor, disp_en, door_open, moving_up, moving_down, pending
  );

  modport slave (
    input  req,
    output floor, disp_en, door_open, moving_up, moving_down, pending
  );

endinterface

// File: rtl/elevator_timer.sv
// Up-counter with synchronous clear; done flags when the count reaches a runtime limit.
module elevator_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/elevator_controller.sv
// Collective (SCAN) elevator sequencer: latches calls, times floor travel and
// door dwell, and drives the floor indicator.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_TICKS = 50,
  parameter int DOOR_TICKS  = 100
) (
  input logic       clk,
  input logic       rst_n,
  elevator_if.slave bus
);

  localparam int TIMER_W = $clog2(max_int(FLOOR_TICKS, DOOR_TICKS));

  state_t                state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d, step_floor;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, clear_bits, door_block;
  logic [NUM_FLOORS-1:0] above_mask, below_mask, here_bit, next_bit, ahead_mask;
  logic                  disp_q;
  logic                  any_up, any_down, ahead, behind;
  logic                  pending_here, pending_next, beyond_next, req_here;
  logic                  timer_clear, timer_done;
  logic [TIMER_W-1:0]    timer_limit;

  assign step_floor = (dir_q == UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  // Thermometer masks of the floors strictly above/below the car, plus one-hot
  // selects for the current floor and the floor the next step lands on.
  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_mask
    assign above_mask[i] = FLOOR_W'(i) > floor_q;
    assign below_mask[i] = FLOOR_W'(i) < floor_q;
    assign here_bit[i]   = FLOOR_W'(i) == floor_q;
    assign next_bit[i]   = FLOOR_W'(i) == step_floor;
  end

  assign any_up       = |(pending_q & above_mask);
  assign any_down     = |(pending_q & below_mask);
  assign ahead        = (dir_q == UP) ? any_up : any_down;
  assign behind       = (dir_q == UP) ? any_down : any_up;
  assign ahead_mask   = (dir_q == UP) ? above_mask : below_mask;
  assign pending_here = |(pending_q & here_bit);
  assign pending_next = |(pending_q & next_bit);
  assign beyond_next  = |(pending_q & ahead_mask & ~next_bit);
  assign req_here     = |(bus.req & here_bit);

  assign timer_clear = (state_q == IDLE) || timer_done || (state_q == DOOR && req_here);
  assign timer_limit = (state_q == MOVE) ? TIMER_W'(FLOOR_TICKS - 1) : TIMER_W'(DOOR_TICKS - 1);

  elevator_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(timer_clear),
    .limit(timer_limit),
    .done (timer_done)
  );

  // A call for the current floor while the door is open only holds the door.
  assign door_block = here_bit & {NUM_FLOORS{state_q == DOOR}};
  assign pending_d  = (pending_q | (bus.req & ~door_block)) & ~clear_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= UP;
      floor_q   <= '0;
      pending_q <= '0;
      disp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      disp_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    floor_d    = floor_q;
    clear_bits = '0;
    case (state_q)
      IDLE: begin
        if (pending_here) begin
          state_d    = DOOR;
          clear_bits = here_bit;
        end else if (ahead) begin
          state_d = MOVE;
        end else if (behind) begin
          dir_d   = (dir_q == UP) ? DOWN : UP;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (timer_done) begin
          floor_d = step_floor;
          if (pending_next) begin
            state_d    = DOOR;
            clear_bits = next_bit;
          end else if (!beyond_next) begin
            state_d = IDLE;
          end
        end
      end
      DOOR: begin
        if (timer_done && !req_here) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.floor       = floor_q;
    bus.pending     = pending_q;
    bus.disp_en     = disp_q;
    bus.door_open   = (state_q == DOOR);
    bus.moving_up   = (state_q == MOVE) && (dir_q == UP);
    bus.moving_down = (state_q == MOVE) && (dir_q == DOWN);
  end

  // The scheduler only moves toward a pending call, so the car never runs off either end.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == MOVE && timer_done &&
      ((dir_q == UP && floor_q == FLOOR_W'(NUM_FLOORS - 1)) ||
       (dir_q == DOWN && floor_q == '0))));

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// calls compared every cycle against a behavioural elevator model.
module tb_elevator_controller;

  localparam int NF = 10;
  localparam int FT = 4;
  localparam int DT = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] r;
  int            checks = 0;
  int            errors = 0;

  elevator_if #(.NUM_FLOORS(NF)) bus ();

  elevator_controller #(
    .NUM_FLOORS (NF),
    .FLOOR_TICKS(FT),
    .DOOR_TICKS (DT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: the car is idle, travelling (cycles left until the next floor) or
  // holding the door (cycles left before it closes); calls is the set of floors to visit.
  typedef struct packed {
    logic          shown;
    logic          moving;
    logic          door;
    logic          up;
    int            at;
    int            travel_left;
    int            door_left;
    logic [NF-1:0] calls;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t n;
    n.shown       = 1'b0;
    n.moving      = 1'b0;
    n.door        = 1'b0;
    n.up          = 1'b1;
    n.at          = 0;
    n.travel_left = 0;
    n.door_left   = 0;
    n.calls       = '0;
    return n;
  endfunction

  function automatic logic calls_beyond(input logic [NF-1:0] c, input int f, input logic up);
    logic any = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (c[i] && ((up && i > f) || (!up && i < f))) any = 1'b1;
    end
    return any;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic [NF-1:0] rq);
    model_t n = cur;
    n.shown = 1'b1;
    for (int i = 0; i < NF; i++) begin
      if (rq[i] && !(cur.door && i == cur.at)) n.calls[i] = 1'b1;
    end
    if (cur.door) begin
      if (rq[cur.at]) n.door_left = DT;
      else if (cur.door_left == 1) n.door = 1'b0;
      else n.door_left = cur.door_left - 1;
    end else if (cur.moving) begin
      if (cur.travel_left == 1) begin
        n.at = cur.up ? cur.at + 1 : cur.at - 1;
        if (cur.calls[n.at]) begin
          n.moving       = 1'b0;
          n.door         = 1'b1;
          n.door_left    = DT;
          n.calls[n.at]  = 1'b0;
        end else if (calls_beyond(cur.calls, n.at, cur.up)) begin
          n.travel_left = FT;
        end else begin
          n.moving = 1'b0;
        end
      end else begin
        n.travel_left = cur.travel_left - 1;
      end
    end else begin
      if (cur.calls[cur.at]) begin
        n.door          = 1'b1;
        n.door_left     = DT;
        n.calls[cur.at] = 1'b0;
      end else if (calls_beyond(cur.calls, cur.at, cur.up)) begin
        n.moving      = 1'b1;
        n.travel_left = FT;
      end else if (calls_beyond(cur.calls, cur.at, !cur.up)) begin
        n.up          = !cur.up;
        n.moving      = 1'b1;
        n.travel_left = FT;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_next(m, bus.req);
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle the registered outputs must agree with the model.
  always @(negedge clk) begin
    check_output("model_floor", int'(bus.floor), m.at);
    check_output("model_disp_en", int'(bus.disp_en), int'(m.shown));
    check_output("model_door_open", int'(bus.door_open), int'(m.door));
    check_output("model_moving_up", int'(bus.moving_up), int'(m.moving && m.up));
    check_output("model_moving_down", int'(bus.moving_down), int'(m.moving && !m.up));
    check_output("model_pending", int'(bus.pending), int'(m.calls));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [NF-1:0] value);
    bus.req = value;
    tick(1);
    bus.req = '0;
  endtask

  task automatic wait_door(input int exp_floor, input int exp_len);
    int n = 0;
    while (!bus.door_open && n < 400) begin
      tick(1);
      n++;
    end
    check_output("door_reached", int'(bus.door_open), 1);
    check_output("door_floor", int'(bus.floor), exp_floor);
    n = 0;
    while (bus.door_open && n < 400) begin
      tick(1);
      n++;
    end
    check_output("door_len", n, exp_len);
  endtask

  initial begin
    bus.req = '0;
    r       = '0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    tick(3);

    // Reset release: display turns on one edge later, car idles at floor 0.
    rst_n = 1'b1;
    check_output("rst_disp_en", int'(bus.disp_en), 0);
    check_output("rst_floor", int'(bus.floor), 0);
    tick(1);
    check_output("rel_disp_en", int'(bus.disp_en), 1);
    check_output("rel_idle_moving", int'(bus.moving_up | bus.moving_down | bus.door_open), 0);
    tick(2);
    check_output("idle_stays", int'(bus.moving_up | bus.moving_down | bus.door_open), 0);

    // Call at the current floor opens the door without moving.
    apply_stimulus(NF'(1));
    check_output("here_pending", int'(bus.pending), 1);
    check_output("here_not_open_yet", int'(bus.door_open), 0);
    tick(1);
    check_output("here_door", int'(bus.door_open), 1);
    check_output("here_cleared", int'(bus.pending), 0);
    wait_door(0, DT);

    // Single call to floor 3.
    apply_stimulus(NF'(1) << 3);
    check_output("a_pending", int'(bus.pending), 8);
    check_output("a_not_moving", int'(bus.moving_up), 0);
    tick(1);
    check_output("a_move_up", int'(bus.moving_up), 1);
    check_output("a_floor0", int'(bus.floor), 0);
    tick(4);
    check_output("a_floor1", int'(bus.floor), 1);
    tick(7);
    check_output("a_floor2", int'(bus.floor), 2);
    check_output("a_still_up", int'(bus.moving_up), 1);
    tick(1);
    check_output("a_floor3", int'(bus.floor), 3);
    check_output("a_door", int'(bus.door_open), 1);
    check_output("a_pending_clear", int'(bus.pending), 0);
    wait_door(3, DT);

    // Door hold: call for floor 4 again on the last door cycle restarts dwell.
    apply_stimulus(NF'(1) << 4);
    tick(4);
    check_output("h_floor3", int'(bus.floor), 3);
    tick(1);
    check_output("h_door", int'(bus.door_open), 1);
    check_output("h_floor4", int'(bus.floor), 4);
    tick(5);
    check_output("h_door_last", int'(bus.door_open), 1);
    apply_stimulus(NF'(1) << 4);
    check_output("h_door_held", int'(bus.door_open), 1);
    check_output("h_pending_zero", int'(bus.pending), 0);
    wait_door(4, DT);

    // SCAN ordering: heading up through 5 toward 7, calls at 2 and 8 arrive.
    apply_stimulus(NF'(1) << 7);
    tick(5);
    check_output("s_floor5", int'(bus.floor), 5);
    check_output("s_up", int'(bus.moving_up), 1);
    apply_stimulus((NF'(1) << 2) | (NF'(1) << 8));
    check_output("s_pending", int'(bus.pending), 388);
    wait_door(7, DT);
    wait_door(8, DT);
    tick(1);
    check_output("s_reverse", int'(bus.moving_down), 1);
    wait_door(2, DT);

    // Asynchronous reset while moving up past floor 3.
    apply_stimulus(NF'(1) << 6);
    for (int n = 0; n < 100 && bus.floor != 4'd3; n++) tick(1);
    check_output("r_floor3", int'(bus.floor), 3);
    check_output("r_up", int'(bus.moving_up), 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("r_floor0", int'(bus.floor), 0);
    check_output("r_pending0", int'(bus.pending), 0);
    check_output("r_stopped", int'(bus.moving_up | bus.moving_down | bus.door_open), 0);
    check_output("r_disp0", int'(bus.disp_en), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_output("r_disp1", int'(bus.disp_en), 1);

    // Random calls, including door-hold presses, with one reset partway through.
    for (int c = 0; c < 3000; c++) begin
      r = '0;
      case ($urandom_range(0, 11))
        0, 1: r[$urandom_range(0, NF - 1)] = 1'b1;
        2: if (m.door) r[m.at] = 1'b1;
        3: r = NF'($urandom) & NF'($urandom);
        default: r = '0;
      endcase
      if (c == 1500) begin
        bus.req = '0;
        #2 rst_n = 1'b0;
        #1;
        check_output("rr_floor0", int'(bus.floor), 0);
        check_output("rr_pending0", int'(bus.pending), 0);
        tick(1);
        rst_n = 1'b1;
      end
      bus.req = r;
      tick(1);
    end
    bus.req = '0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
